// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Asynchronous active-low reset clears every register; out-of-range addresses read 0 and drop writes.
module reg_file_32x32 #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [ADDR_W-1:0] R1,
   input  logic [ADDR_W-1:0] R2,
   input  logic [ADDR_W-1:0] Rw,
   input  logic [DATA_W-1:0] Din,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];

   // Full-width address match per entry, so addresses >= DEPTH never alias onto a register.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_next
         always_comb begin
            regs_d[gi] = regs_q[gi];
            if (wr && (Rw == ADDR_W'(gi))) begin
               regs_d[gi] = Din;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // No write bypass: reads always show the currently stored value.
   always_comb begin
      OUT1 = '0;
      OUT2 = '0;
      if (R1 < DEPTH_A) begin
         OUT1 = regs_q[R1[IDX_W-1:0]];
      end
      if (R2 < DEPTH_A) begin
         OUT2 = regs_q[R2[IDX_W-1:0]];
      end
   end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed-vector bench for reg_file_32x32 with hand-computed expected values.
module tb_reg_file_32x32;

   logic        clk;
   logic        rst_n;
   logic        wr;
   logic [5:0]  R1;
   logic [5:0]  R2;
   logic [5:0]  Rw;
   logic [31:0] Din;
   logic [31:0] OUT1;
   logic [31:0] OUT2;

   int tests_run;
   int tests_failed;

   reg_file_32x32 dut (
      .clk  (clk),
      .rst_n(rst_n),
      .wr   (wr),
      .R1   (R1),
      .R2   (R2),
      .Rw   (Rw),
      .Din  (Din),
      .OUT1 (OUT1),
      .OUT2 (OUT2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic write_reg(input logic [5:0] addr, input logic [31:0] data);
      @(negedge clk);
      wr  = 1'b1;
      Rw  = addr;
      Din = data;
      @(posedge clk);
      #1;
      wr  = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      wr    = 1'b0;
      R1    = 6'd0;
      R2    = 6'd0;
      Rw    = 6'd0;
      Din   = 32'd0;

      #3;
      check("reset_out1", OUT1, 32'd0);
      check("reset_out2", OUT2, 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_reset_out1", OUT1, 32'd0);

      // Test 1: asynchronous reset between clock edges
      write_reg(6'd5, 32'hDEADBEEF);
      R1 = 6'd5;
      #1;
      check("t1_reg5_written", OUT1, 32'hDEADBEEF);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_reg5_async_clear", OUT1, 32'd0);
      rst_n = 1'b1;
      #1;
      check("t1_reg5_after_release", OUT1, 32'd0);

      // Test 2: sequential fill k=1..31 with 2k, then sweep both ports
      for (int k = 1; k < 32; k++) begin
         write_reg(6'(k), 32'(2 * k));
      end
      R1 = 6'd0;
      #1;
      check("t2_reg0_untouched", OUT1, 32'd0);
      for (int k = 1; k < 32; k++) begin
         R1 = 6'(k);
         R2 = 6'(k + 1);
         #1;
         check($sformatf("t2_out1_r%0d", k), OUT1, 32'(2 * k));
         check($sformatf("t2_out2_r%0d", k + 1), OUT2, (k + 1 < 32) ? 32'(2 * (k + 1)) : 32'd0);
      end

      // Test 3: out-of-range write dropped, out-of-range reads return 0
      write_reg(6'd32, 32'd64);
      R1 = 6'd0;
      #1;
      check("t3_reg0_no_alias", OUT1, 32'd0);
      R1 = 6'd32;
      #1;
      check("t3_read_32", OUT1, 32'd0);
      R1 = 6'd63;
      R2 = 6'd33;
      #1;
      check("t3_read_63", OUT1, 32'd0);
      check("t3_read_33", OUT2, 32'd0);
      R1 = 6'd1;
      #1;
      check("t3_reg1_intact", OUT1, 32'd2);

      // Test 4: write enable low
      @(negedge clk);
      wr  = 1'b0;
      Rw  = 6'd3;
      Din = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      R1 = 6'd3;
      #1;
      check("t4_wr_low_reg3", OUT1, 32'd6);

      // Test 5: read during write shows old value until the edge
      @(negedge clk);
      R1  = 6'd7;
      Rw  = 6'd7;
      Din = 32'h00001234;
      wr  = 1'b1;
      #1;
      check("t5_before_edge", OUT1, 32'd14);
      @(posedge clk);
      #1;
      check("t5_after_edge", OUT1, 32'h00001234);
      wr = 1'b0;

      // Test 6: dual port on the same register, then independent change
      R1 = 6'd10;
      R2 = 6'd10;
      #1;
      check("t6_out1_r10", OUT1, 32'd20);
      check("t6_out2_r10", OUT2, 32'd20);
      R1 = 6'd0;
      #1;
      check("t6_out1_r0", OUT1, 32'd0);
      check("t6_out2_hold", OUT2, 32'd20);

      // Register 0 is writable
      write_reg(6'd0, 32'hA5A5A5A5);
      #1;
      check("reg0_writable", OUT1, 32'hA5A5A5A5);
      check("reg0_write_no_side", OUT2, 32'd20);

      // Final reset clears everything
      rst_n = 1'b0;
      R1 = 6'd31;
      R2 = 6'd7;
      #1;
      check("final_reset_r31", OUT1, 32'd0);
      check("final_reset_r7", OUT2, 32'd0);
      rst_n = 1'b1;
      #1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
